// File: rtl/sha256_round_sched.sv
// SHA-256 block sequencer: loads 16-word blocks, expands W_t in a sliding window,
// drives one external compression unit for 64 rounds and folds results into H.
module sha256_round_sched #(
  parameter int unsigned DELAY_W = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               blk_valid,
  output logic               blk_ready,
  input  logic [DATA_W-1:0]  blk_data,
  input  logic               blk_last,
  output logic               dig_valid,
  input  logic               dig_ready,
  output logic [255:0]       dig_data,
  output logic               busy,
  output logic               unit_run,
  output logic [DELAY_W-1:0] unit_delay,
  output logic [255:0]       unit_state_in,
  output logic [31:0]        unit_w,
  output logic [31:0]        unit_k,
  input  logic [255:0]       unit_state_out
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] ROUND = 3'd3;
  localparam logic [2:0] FINAL = 3'd4;
  localparam logic [2:0] OUT   = 3'd5;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  rnd_q, rnd_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [31:0] h_q [8];
  logic [31:0] h_d [8];
  logic        first_q, first_d;
  logic        last_q, last_d;
  logic        ready_q, ready_d;
  logic        accept;
  logic [31:0] w_new;
  logic [255:0] h_flat;

  assign accept = blk_valid & ready_q;
  assign w_new  = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rnd_d   = rnd_q;
    win_d   = win_q;
    h_d     = h_q;
    first_d = first_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (accept) begin
        for (int unsigned i = 0; i < 15; i++) win_d[i] = win_q[i+1];
        win_d[15] = blk_data;
        cnt_d     = 4'd1;
        if (first_q) begin
          h_d     = IV;
          first_d = 1'b0;
        end
        state_d = LOAD;
      end
      LOAD: if (accept) begin
        for (int unsigned i = 0; i < 15; i++) win_d[i] = win_q[i+1];
        win_d[15] = blk_data;
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          last_d  = blk_last;
          state_d = START;
        end
      end
      START: begin
        rnd_d   = '0;
        state_d = ROUND;
      end
      ROUND: begin
        for (int unsigned i = 0; i < 15; i++) win_d[i] = win_q[i+1];
        win_d[15] = w_new;
        rnd_d     = rnd_q + 6'd1;
        if (rnd_q == 6'd63) state_d = FINAL;
      end
      FINAL: begin
        for (int unsigned i = 0; i < 8; i++) h_d[i] = h_q[i] + unit_state_out[255-32*i -: 32];
        state_d = last_q ? OUT : LOAD;
      end
      OUT: if (dig_ready) begin
        first_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // ready is registered from the next state so it reads 0 while in reset
    ready_d = (state_d == IDLE) || (state_d == LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rnd_q   <= '0;
      win_q   <= '{default: '0};
      h_q     <= IV;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rnd_q   <= rnd_d;
      win_q   <= win_d;
      h_q     <= h_d;
      first_q <= first_d;
      last_q  <= last_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    h_flat = '0;
    for (int unsigned i = 0; i < 8; i++) h_flat[255-32*i -: 32] = h_q[i];
  end

  assign blk_ready     = ready_q;
  assign dig_valid     = (state_q == OUT);
  assign dig_data      = (state_q == OUT) ? h_flat : '0;
  assign busy          = (state_q != IDLE) && (state_q != LOAD);
  assign unit_run      = (state_q == START);
  assign unit_delay    = '0;
  assign unit_state_in = h_flat;
  assign unit_w        = (state_q == ROUND) ? win_q[0] : '0;
  assign unit_k        = (state_q == ROUND) ? K[rnd_q] : '0;

endmodule

// File: tb/tb_sha256_round_sched.sv
// Bench for sha256_round_sched: behavioural compression unit, vector table of
// messages with known digests, digest scoreboard and multi-cycle corner sequences.
module tb_sha256_round_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         blk_valid, blk_ready, blk_last;
  logic [31:0]  blk_data;
  logic         dig_valid, dig_ready;
  logic [255:0] dig_data;
  logic         busy, unit_run;
  logic [31:0]  unit_delay;
  logic [255:0] unit_state_in, unit_state_out;
  logic [31:0]  unit_w, unit_k;

  always #5 clk = ~clk;

  sha256_round_sched #(.DELAY_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
    .busy(busy), .unit_run(unit_run), .unit_delay(unit_delay),
    .unit_state_in(unit_state_in), .unit_w(unit_w), .unit_k(unit_k),
    .unit_state_out(unit_state_out)
  );

  localparam logic [255:0] IV_FLAT =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] DIG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int runs = 0;
  logic dv_prev = 1'b0;
  logic [255:0] sb[$];

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // behavioural compression unit: latches run, then one round per cycle
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] w, input logic [31:0] k);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  logic [255:0] u_st = '0;
  logic u_arm = 1'b0;
  int u_cnt = 0;
  assign unit_state_out = u_st;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (unit_run) begin
      u_arm <= 1'b1;
      u_cnt <= 0;
    end else if (u_arm) begin
      u_st  <= sha_round((u_cnt == 0) ? unit_state_in : u_st, unit_w, unit_k);
      u_cnt <= u_cnt + 1;
    end
  end

  // output monitor / scoreboard
  always @(negedge clk) begin
    if (unit_run) runs++;
    if (dig_valid) begin
      check("blk_ready_low_in_out", {255'd0, blk_ready}, 256'd0);
      if (!dv_prev) check("digest_latency", 256'(cyc - acc_cyc), 256'd67);
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_digest: got %h expected none", dig_data);
      end else begin
        check("digest", dig_data, sb[0]);
        if (dig_ready) void'(sb.pop_front());
      end
    end
    dv_prev = dig_valid;
  end

  typedef struct packed {
    logic [1:0][15:0][31:0] w;
    logic [255:0]           dig;
    logic [1:0]             nb;
  } vec_t;

  vec_t tv [3];

  task automatic send_word(input logic [31:0] d, input logic l, input int gap_max);
    int n;
    logic ok;
    repeat ($urandom_range(0, gap_max)) begin
      @(posedge clk);
      #1;
    end
    blk_valid = 1'b1;
    blk_data  = d;
    blk_last  = l;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = blk_ready;
      if (ok) acc_cyc = cyc;
      @(posedge clk);
      n++;
    end
    #1;
    blk_valid = 1'b0;
    check("word_accepted", {255'd0, ok}, 256'd1);
  endtask

  // blk_last is driven inverted on words 0..14 so only word 15 may decide
  task automatic send_msg(input vec_t v, input int gap_max);
    logic lst;
    sb.push_back(v.dig);
    for (int b = 0; b < int'(v.nb); b++) begin
      lst = (b == int'(v.nb) - 1);
      for (int j = 0; j < 16; j++)
        send_word(v.w[b][j], (j == 15) ? lst : ~lst, gap_max);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 256'(sb.size()), 256'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_blk_ready"}, {255'd0, blk_ready}, 256'd0);
    check({nm, "_dig_valid"}, {255'd0, dig_valid}, 256'd0);
    check({nm, "_unit_run"}, {255'd0, unit_run}, 256'd0);
    check({nm, "_busy"}, {255'd0, busy}, 256'd0);
    check({nm, "_dig_data"}, dig_data, 256'd0);
    check({nm, "_unit_w"}, {224'd0, unit_w}, 256'd0);
    check({nm, "_unit_k"}, {224'd0, unit_k}, 256'd0);
    check({nm, "_unit_delay"}, {224'd0, unit_delay}, 256'd0);
    check({nm, "_state_in_iv"}, unit_state_in, IV_FLAT);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m2 [32];
    int r0, n;

    m2 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
           32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
           32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
           32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000,
           32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
           32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000001c0};

    tv[0] = '0;
    tv[0].nb = 2'd1;
    tv[0].w[0][0]  = 32'h61626380;
    tv[0].w[0][15] = 32'h00000018;
    tv[0].dig = DIG_ABC;

    tv[1] = '0;
    tv[1].nb = 2'd1;
    tv[1].w[0][0] = 32'h80000000;
    tv[1].dig = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    tv[2] = '0;
    tv[2].nb = 2'd2;
    for (int i = 0; i < 32; i++) tv[2].w[i/16][i%16] = m2[i];
    tv[2].dig = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    rst_n = 1'b0;
    blk_valid = 1'b0;
    blk_data = '0;
    blk_last = 1'b0;
    dig_ready = 1'b1;
    #22;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // table of complete messages
    for (int i = 0; i < 3; i++) begin
      r0 = runs;
      send_msg(tv[i], 0);
      wait_drain();
      check("unit_run_per_block", 256'(runs - r0), 256'(tv[i].nb));
    end

    // back-to-back "abc", first digest held for 10 cycles with next word pending
    r0 = runs;
    dig_ready = 1'b0;
    send_msg(tv[0], 0);
    blk_valid = 1'b1;
    blk_data  = 32'h61626380;
    blk_last  = 1'b0;
    n = 0;
    while (!dig_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("hold_dig_valid_seen", {255'd0, dig_valid}, 256'd1);
    repeat (10) @(negedge clk);
    check("hold_dig_valid_still", {255'd0, dig_valid}, 256'd1);
    @(posedge clk);
    #1;
    dig_ready = 1'b1;
    send_msg(tv[0], 0);
    wait_drain();
    check("unit_run_back_to_back", 256'(runs - r0), 256'd2);

    // "abc" with random valid gaps during load
    r0 = runs;
    send_msg(tv[0], 1);
    wait_drain();
    check("unit_run_gapped", 256'(runs - r0), 256'd1);

    // asynchronous reset in round 30, then a clean "abc"
    send_msg(tv[0], 0);
    repeat (31) @(posedge clk);
    #1;
    check("round30_busy", {255'd0, busy}, 256'd1);
    check("round30_k", {224'd0, unit_k}, {224'd0, 32'h06ca6351});
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    r0 = runs;
    send_msg(tv[0], 0);
    wait_drain();
    check("unit_run_after_reset", 256'(runs - r0), 256'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
